ram_io_responder: RTL and testbench

- Responder end of the byte-wide memory bus (mem_aout/mem_dout/mem_rw/mem_din/io_buffer_full) that the memory controller initiates on.
- Provides the byte RAM with 1-cycle read latency and the memory-mapped IO window: UART tx FIFO, UART rx FIFO and simulation-end flag.
- Sits at top level between the CPU's memory controller and the UART/host side.
- Drives io_buffer_full back to the controller as flow control.

---
 rtl/ram_io_responder_pkg.sv | 30 +++
 rtl/ram_io_responder_fifo.sv | 53 +++++
 rtl/ram_io_responder.sv | 140 ++++++++++++++
 tb/tb_ram_io_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared address map and decode helper for the RAM/IO responder.
package ram_io_responder_pkg;

  localparam int RAM_ADDR_BITS_DEF = 17;

  // IO window selected by these two address bits
  localparam logic [1:0] IO_REGION = 2'b11;

  // IO register addresses (low 18 bits of the bus address)
  localparam logic [17:0] UART_DATA_ADDR = 18'h30000;
  localparam logic [17:0] SIM_END_ADDR   = 18'h30004;

  typedef enum logic [1:0] {
    IO_NONE,
    IO_UART,
    IO_SIM_END
  } io_sel_e;

  // Map an IO-window address to the register it hits
  function automatic io_sel_e io_decode(input logic [17:0] addr);
    io_sel_e sel;
    sel = IO_NONE;
    if (addr == UART_DATA_ADDR)
      sel = IO_UART;
    else if (addr == SIM_END_ADDR)
      sel = IO_SIM_END;
    return sel;
  endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// Synchronous FIFO: push ignored when full, pop ignored when empty,
// head visible on dout without a read strobe.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Responder side of the byte memory bus: byte RAM with 1-cycle read
// latency plus an IO window holding the UART tx/rx FIFOs and sim_end flag.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int TX_DEPTH      = 8,
  parameter int RX_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  mem_rw,
  input  logic [ADDR_WIDTH-1:0] mem_aout,
  input  logic [7:0]            mem_dout,
  output logic [7:0]            mem_din,
  output logic                  io_buffer_full,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  sim_end
);

  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  // Two entries of slack: one write may already be in flight when the flag rises
  localparam logic [TCW-1:0] TX_FULL_AT = TCW'(TX_DEPTH - 2);

  logic [7:0]               ram [2**RAM_ADDR_BITS];
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic                     is_io;
  io_sel_e                  io_sel;
  logic                     ram_we, sim_set;
  logic [7:0]               ram_q, io_q, io_rd;
  logic                     from_ram;

  logic                     tx_push, tx_pop, tx_push_ok, tx_full, tx_empty;
  logic [TCW-1:0]           tx_count, tx_count_nxt;
  logic                     rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]               rx_head;
  logic [RCW-1:0]           rx_count_unused;
  logic                     addr_unused;

  // Upper address bits do not take part in decode
  assign addr_unused = ^mem_aout;

  assign ram_addr = mem_aout[RAM_ADDR_BITS-1:0];
  assign is_io    = (mem_aout[17:16] == IO_REGION);
  assign io_sel   = is_io ? io_decode(mem_aout[17:0]) : IO_NONE;

  assign ram_we     = rdy_in && mem_rw && !is_io;
  assign sim_set    = rdy_in && mem_rw && (io_sel == IO_SIM_END);
  assign tx_push    = rdy_in && mem_rw && (io_sel == IO_UART);
  assign tx_push_ok = tx_push && !tx_full;
  assign tx_valid   = !tx_empty;
  assign tx_pop     = tx_valid && tx_ready;

  // An IO read of an empty rx FIFO returns 0 and must not pop, even when
  // the UART pushes in the same cycle
  assign rx_pop   = rdy_in && !mem_rw && (io_sel == IO_UART) && !rx_empty;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  // IO read data selected by the decoded register
  always_comb begin
    io_rd = '0;
    if (is_io && !mem_rw) begin
      case (io_sel)
        IO_UART:    io_rd = rx_empty ? 8'h00 : rx_head;
        IO_SIM_END: io_rd = {7'b0, !rx_empty};
        default:    io_rd = '0;
      endcase
    end
  end

  // tx occupancy after this edge, used for registered flow control
  always_comb begin
    tx_count_nxt = tx_count;
    case ({tx_push_ok, tx_pop})
      2'b10:   tx_count_nxt = tx_count + TCW'(1);
      2'b01:   tx_count_nxt = tx_count - TCW'(1);
      default: tx_count_nxt = tx_count;
    endcase
  end

  // RAM array, read-first so a write returns the old byte; no reset on contents
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
    if (rdy_in) ram_q <= ram[ram_addr];
  end

  // Read-source select, IO read data, sim_end and flow-control flag
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      from_ram       <= 1'b0;
      io_q           <= '0;
      sim_end        <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      io_buffer_full <= (tx_count_nxt >= TX_FULL_AT);
      if (rdy_in) begin
        from_ram <= !is_io;
        io_q     <= io_rd;
        if (sim_set) sim_end <= 1'b1;
      end
    end
  end

  // Reset forces from_ram low and io_q to zero, so mem_din clears at once
  assign mem_din = from_ram ? ram_q : io_q;

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_in),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (mem_dout),
    .dout  (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_in),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .count (rx_count_unused),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench: stimulus queues expected read bytes and tx bytes,
// a negedge monitor pops and compares as the DUT produces them.
module tb_ram_io_responder;

  localparam int TXD = 8;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        mem_rw = 1'b0;
  logic [31:0] mem_aout = '0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        sim_end;

  ram_io_responder dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .mem_rw(mem_rw),
    .mem_aout(mem_aout), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .sim_end(sim_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: read data is due one edge after issue; tx bytes on each handshake
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        while (rd_q.size() > 0 && rd_q[0].cyc + 1 <= cyc) begin
          e = rd_q.pop_front();
          chk(e.name, mem_din, e.val);
        end
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected got=%0h exp=none", tx_data);
          end else begin
            chk("tx_data", tx_data, tx_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; mem_rw = 1'b0; mem_aout = '0; mem_dout = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    rdy_in = 1'b1; mem_rw = 1'b1; mem_aout = a; mem_dout = d;
    if (a[17:0] == 18'h30000 && tx_q.size() < TXD) tx_q.push_back(d);
    step();
    idle();
  endtask

  task automatic wr_old(input logic [31:0] a, input logic [7:0] d, input logic [7:0] old);
    rd_q.push_back('{cyc, old, "ram_write_old"});
    wr(a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] v, input string name);
    rdy_in = 1'b1; mem_rw = 1'b0; mem_aout = a;
    rd_q.push_back('{cyc, v, name});
    step();
    idle();
  endtask

  task automatic stall_rd(input logic [31:0] a, input logic [7:0] hold, input string name);
    rdy_in = 1'b0; mem_rw = 1'b0; mem_aout = a;
    rd_q.push_back('{cyc, hold, name});
    step();
    idle();
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2 rst_in = 1'b0;
    #10;
    chk("rst_mem_din", mem_din, 0);
    chk("rst_ibf", io_buffer_full, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_sim_end", sim_end, 0);
    @(posedge clk); #1;
    rst_in = 1'b1;

    // RAM write/read, read-first on write
    wr(32'h10, 8'hA5);
    rd(32'h10, 8'hA5, "ram_rd_a5");
    wr_old(32'h10, 8'h5A, 8'hA5);
    rd(32'h10, 8'h5A, "ram_rd_5a");
    wr(32'h1_0010, 8'h3C);
    rd(32'h1_0010, 8'h3C, "ram_rd_hi");
    rd(32'h10, 8'h5A, "ram_rd_alias");

    // tx fill with UART stalled, then drain
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(32'h30000, 8'h41 + 8'(i));
      if (i == 4) chk("ibf_after5", io_buffer_full, 0);
    end
    chk("ibf_after6", io_buffer_full, 1);
    chk("tx_valid_filled", tx_valid, 1);
    tx_ready = 1'b1;
    step();
    chk("ibf_after_pop", io_buffer_full, 0);
    repeat (7) step();
    chk("tx_valid_drained", tx_valid, 0);
    chk("tx_q_drained", tx_q.size(), 0);

    // rx path
    rx_push(8'h31);
    rx_push(8'h32);
    rd(32'h30008, 8'h00, "io_other_rd");
    wr(32'h30008, 8'hEE);
    rd(32'h30004, 8'h01, "rx_status_1");
    rd(32'h30000, 8'h31, "rx_pop_31");
    rd(32'h30000, 8'h32, "rx_pop_32");
    rd(32'h30004, 8'h00, "rx_status_0");
    rd(32'h30000, 8'h00, "rx_pop_empty");
    // same-cycle push with empty pop: returns 0, byte stays
    rx_valid = 1'b1; rx_data = 8'h99;
    rd(32'h30000, 8'h00, "rx_empty_pop_push");
    rx_valid = 1'b0;
    rd(32'h30000, 8'h99, "rx_kept_99");
    // same-cycle push and pop on non-empty
    rx_push(8'hAA);
    rx_valid = 1'b1; rx_data = 8'hBB;
    rd(32'h30000, 8'hAA, "rx_pop_aa");
    rx_valid = 1'b0;
    rd(32'h30000, 8'hBB, "rx_pop_bb");
    rd(32'h30004, 8'h00, "rx_status_empty");
    // rx full: ninth byte refused
    for (int i = 0; i < 9; i++) rx_push(8'h50 + 8'(i));
    chk("rx_ready_full", rx_ready, 0);
    for (int i = 0; i < 8; i++) rd(32'h30000, 8'h50 + 8'(i), "rx_full_drain");
    rd(32'h30000, 8'h00, "rx_full_empty");
    chk("rx_ready_again", rx_ready, 1);

    // rdy_in stall: no RAM write, no tx push, no rx pop; UART side runs
    tx_ready = 1'b1;
    wr(32'h20, 8'h11);
    rd(32'h20, 8'h11, "ram_pre_stall");
    rdy_in = 1'b0; mem_rw = 1'b1; mem_aout = 32'h20; mem_dout = 8'h77;
    rx_valid = 1'b1; rx_data = 8'h61;
    step();
    rx_valid = 1'b0; mem_aout = 32'h30000; mem_dout = 8'h88;
    step();
    stall_rd(32'h30000, 8'h11, "stall_hold");
    rd(32'h20, 8'h11, "ram_after_stall");
    rd(32'h30000, 8'h61, "rx_during_stall");
    rd(32'h30004, 8'h00, "rx_empty_after_stall");
    chk("tx_no_push_stall", tx_valid, 0);

    // tx simultaneous push/pop with wrap, then fill to full
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h30000, 8'h60 + 8'(i));
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) wr(32'h30000, 8'h70 + 8'(i));
    chk("ibf_steady3", io_buffer_full, 0);
    tx_ready = 1'b0;
    wr(32'h30000, 8'h80);
    wr(32'h30000, 8'h81);
    chk("ibf_count5", io_buffer_full, 0);
    wr(32'h30000, 8'h82);
    chk("ibf_count6", io_buffer_full, 1);
    wr(32'h30000, 8'h83);
    wr(32'h30000, 8'h84);
    wr(32'h30000, 8'h85);
    chk("ibf_full", io_buffer_full, 1);
    tx_ready = 1'b1;
    repeat (10) step();
    chk("tx_valid_wrap_drained", tx_valid, 0);
    chk("tx_q_wrap_drained", tx_q.size(), 0);

    // sim_end sticky, then asynchronous reset mid-cycle
    wr(32'h30004, 8'h01);
    chk("sim_end_set", sim_end, 1);
    repeat (3) step();
    chk("sim_end_held", sim_end, 1);
    tx_ready = 1'b0;
    wr(32'h30000, 8'h99);
    rx_push(8'h44);
    rd(32'h10, 8'h5A, "ram_pre_reset");
    @(negedge clk); #1;
    rst_in = 1'b0;
    #1;
    chk("arst_sim_end", sim_end, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_mem_din", mem_din, 0);
    chk("arst_ibf", io_buffer_full, 0);
    chk("arst_rx_ready", rx_ready, 1);
    tx_q.delete();
    @(posedge clk); #1;
    rst_in = 1'b1;
    rd(32'h30004, 8'h00, "rx_empty_after_reset");
    rd(32'h10, 8'h5A, "ram_kept_reset");
    chk("sim_end_after_reset", sim_end, 0);
    tx_ready = 1'b1;
    repeat (3) step();

    chk("rd_q_empty", rd_q.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
